// File: rtl/io_port_device.sv
// io_port_device: CPU I/O-port responder with an RX FIFO for inbound external
// words and a TX holding register with a valid/ready handshake.
// Register map (offset from p_base_port): 0 RXDATA (rd, pops), 1 STATUS (rd),
// 2 TXDATA (wr), 3 CTRL (wr). Read data is registered and is 0 on every cycle
// that is not the one following an IN strobe, so the bus can be OR-combined.
// Optional feature: define IO_PORT_IRQ_EN to add the o_w_irq output.
//
// Handshake rules: a word moves across an interface only on a rising edge
// where valid && ready. Here, ext_valid/ext_ready push into the RX FIFO, and
// tx_valid/tx_ready hand the TX word to the sink. o_w_ext_ready is
// combinational (!full). It does not depend on i_w_ext_valid.
module io_port_device #(
    parameter int                      p_data_width     = 16,
    parameter int                      p_port_width     = 8,
    parameter logic [p_port_width-1:0] p_base_port      = 8'h10,
    parameter int                      p_fifo_depth_log = 2
) (
    input  logic                    i_w_clk,
    input  logic                    i_w_reset,
    input  logic [p_port_width-1:0] i_w_io_addr,
    input  logic                    i_w_io_rd,
    input  logic                    i_w_io_wr,
    input  logic [p_data_width-1:0] i_w_io_in,
    output logic [p_data_width-1:0] o_w_io_out,
    input  logic                    i_w_ext_valid,
    input  logic [p_data_width-1:0] i_w_ext_data,
    output logic                    o_w_ext_ready,
    output logic                    o_w_tx_valid,
    output logic [p_data_width-1:0] o_w_tx_data,
`ifdef IO_PORT_IRQ_EN
    output logic                    o_w_irq,
`endif
    input  logic                    i_w_tx_ready
);

    localparam int AW    = p_fifo_depth_log;
    localparam int CW    = p_fifo_depth_log + 1;
    localparam int DEPTH = 2 ** p_fifo_depth_log;

    logic [p_data_width-1:0] mem_q [DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    overrun_q, overrun_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [p_data_width-1:0] tx_data_q, tx_data_d;
    logic [p_data_width-1:0] io_out_q, io_out_d;
    logic                    irq_bit;

    // Address decode: an offset outside 0..3 matches no register.
    logic [p_port_width-1:0] offset;
    logic                    hit;
    logic                    rd_only;
    logic                    sel_rx, sel_st, sel_tx, sel_ctrl;
    logic                    rx_empty, rx_full;
    logic                    push, pop, underflow, flush, clr_ovr, tx_load, tx_take;
    logic [p_data_width-1:0] status_word;

    assign offset   = i_w_io_addr - p_base_port;
    assign hit      = (offset[p_port_width-1:2] == '0);
    assign sel_rx   = hit && (offset[1:0] == 2'd0);
    assign sel_st   = hit && (offset[1:0] == 2'd1);
    assign sel_tx   = hit && (offset[1:0] == 2'd2);
    assign sel_ctrl = hit && (offset[1:0] == 2'd3);

    // A read that coincides with a write is dropped: the write takes priority.
    assign rd_only   = i_w_io_rd && !i_w_io_wr;
    assign rx_empty  = (count_q == '0);
    assign rx_full   = (count_q == CW'(DEPTH));
    assign o_w_ext_ready = !rx_full;

    assign flush     = i_w_io_wr && sel_ctrl && i_w_io_in[0];
    assign clr_ovr   = i_w_io_wr && sel_ctrl && i_w_io_in[1];
    assign push      = i_w_ext_valid && !rx_full && !flush;
    assign pop       = rd_only && sel_rx && !rx_empty;
    assign underflow = rd_only && sel_rx && rx_empty;
    assign tx_load   = i_w_io_wr && sel_tx;
    assign tx_take   = tx_valid_q && i_w_tx_ready;

`ifdef IO_PORT_IRQ_EN
    logic irq_en_q;
    logic irq_q;
    assign irq_bit = irq_q;
    assign o_w_irq = irq_q;

    // Interrupt enable is a sticky CTRL bit; the irq line is registered.
    always_ff @(posedge i_w_clk) begin
        if (!i_w_reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (i_w_io_wr && sel_ctrl) irq_en_q <= i_w_io_in[2];
            irq_q <= (!rx_empty && irq_en_q) || overrun_q;
        end
    end
`else
    assign irq_bit = 1'b0;
`endif

    assign status_word = {{(p_data_width-5){1'b0}}, irq_bit, overrun_q,
                          tx_valid_q, rx_full, rx_empty};

    // Next-state computation for FIFO pointers, overrun, TX register and read data.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        io_out_d   = '0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end

        // Overwriting an unaccepted TX word and reading an empty RX FIFO
        // share the overrun flag; setting wins over clearing.
        if (clr_ovr) overrun_d = 1'b0;
        if (underflow || (tx_load && tx_valid_q && !i_w_tx_ready)) overrun_d = 1'b1;

        if (tx_load) begin
            tx_data_d  = i_w_io_in;
            tx_valid_d = 1'b1;
        end else if (tx_take) begin
            tx_valid_d = 1'b0;
        end

        if (rd_only) begin
            if (sel_rx && !rx_empty) io_out_d = mem_q[rd_ptr_q];
            else if (sel_st)         io_out_d = status_word;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_w_clk) begin
        if (!i_w_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            io_out_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            io_out_q   <= io_out_d;
        end
    end

    // FIFO storage needs no reset: empty entries are never read out.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset && push) mem_q[wr_ptr_q] <= i_w_ext_data;
    end

    assign o_w_io_out   = io_out_q;
    assign o_w_tx_valid = tx_valid_q;
    assign o_w_tx_data  = tx_data_q;

endmodule

// File: tb/tb_io_port_device.sv
// Directed testbench for io_port_device. Inputs change 1 ns after a rising
// edge; outputs are sampled there too, away from the active edge.
module tb_io_port_device;

    localparam logic [7:0] BASE = 8'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  io_addr;
    logic        io_rd, io_wr;
    logic [15:0] io_in;
    logic [15:0] io_out;
    logic        ext_valid;
    logic [15:0] ext_data;
    logic        ext_ready;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;
`ifdef IO_PORT_IRQ_EN
    logic        irq;
`endif

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] rdata;

    // clock / reset block
    always #5 clk = ~clk;

    io_port_device dut (
        .i_w_clk       (clk),
        .i_w_reset     (rst_n),
        .i_w_io_addr   (io_addr),
        .i_w_io_rd     (io_rd),
        .i_w_io_wr     (io_wr),
        .i_w_io_in     (io_in),
        .o_w_io_out    (io_out),
        .i_w_ext_valid (ext_valid),
        .i_w_ext_data  (ext_data),
        .o_w_ext_ready (ext_ready),
        .o_w_tx_valid  (tx_valid),
        .o_w_tx_data   (tx_data),
`ifdef IO_PORT_IRQ_EN
        .o_w_irq       (irq),
`endif
        .i_w_tx_ready  (tx_ready)
    );

    // scoreboard check
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_read(input logic [7:0] addr, output logic [15:0] data);
        io_addr = addr;
        io_rd   = 1'b1;
        tick();
        io_rd   = 1'b0;
        data    = io_out;
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [15:0] data);
        io_addr = addr;
        io_in   = data;
        io_wr   = 1'b1;
        tick();
        io_wr   = 1'b0;
    endtask

    task automatic ext_push(input logic [15:0] data);
        ext_valid = 1'b1;
        ext_data  = data;
        tick();
        ext_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; io_addr = '0; io_rd = 0; io_wr = 0; io_in = '0;
        ext_valid = 0; ext_data = '0; tx_ready = 0;

        // reset held for three cycles
        repeat (3) tick();
        check_eq("rst_io_out",   io_out,   0);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_tx_data",  tx_data,  0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_ext_ready", ext_ready, 1);
        io_read(BASE + 8'd1, rdata);
        check_eq("rst_status", rdata, 16'h0001);

        // fill the FIFO, fifth word refused
        for (int i = 1; i <= 4; i++) begin
            ext_push(16'hA000 + 16'(i));
            check_eq($sformatf("fill_ready%0d", i), ext_ready, (i == 4) ? 0 : 1);
        end
        ext_push(16'hA005);
        io_read(BASE + 8'd1, rdata);
        check_eq("full_status", rdata, 16'h0002);
        for (int i = 1; i <= 4; i++) begin
            io_read(BASE, rdata);
            check_eq($sformatf("pop%0d", i), rdata, 16'hA000 + 16'(i));
        end
        tick();
        check_eq("bus_idle_zero", io_out, 0);
        io_read(BASE + 8'd1, rdata);
        check_eq("drained_status", rdata, 16'h0001);

        // underflow sets overrun; CTRL bit1 clears it
        io_read(BASE, rdata);
        check_eq("underflow_data", rdata, 0);
        io_read(BASE + 8'd1, rdata);
        check_eq("underflow_status", rdata, 16'h0009);
        io_write(BASE + 8'd3, 16'h0002);
        io_read(BASE + 8'd1, rdata);
        check_eq("clr_ovr_status", rdata, 16'h0001);

        // TX load, overwrite while stalled, then drain
        io_write(BASE + 8'd2, 16'h55AA);
        check_eq("tx1_valid", tx_valid, 1);
        check_eq("tx1_data",  tx_data,  16'h55AA);
        io_read(BASE + 8'd1, rdata);
        check_eq("tx1_status", rdata, 16'h0005);
        io_write(BASE + 8'd2, 16'h1234);
        check_eq("tx2_data", tx_data, 16'h1234);
        io_read(BASE + 8'd1, rdata);
        check_eq("tx2_status", rdata, 16'h000D);
        tx_ready = 1'b1;
        tick();
        check_eq("tx_drained", tx_valid, 0);
        tx_ready = 1'b0;
        io_write(BASE + 8'd3, 16'h0002);

        // accept and reload in the same cycle: no overrun
        io_write(BASE + 8'd2, 16'h1111);
        tx_ready = 1'b1;
        io_write(BASE + 8'd2, 16'h4321);
        check_eq("reload_valid", tx_valid, 1);
        check_eq("reload_data",  tx_data,  16'h4321);
        tick();
        check_eq("reload_drained", tx_valid, 0);
        tx_ready = 1'b0;
        io_read(BASE + 8'd1, rdata);
        check_eq("reload_status", rdata, 16'h0001);

        // simultaneous push and pop with two entries
        ext_push(16'hB001);
        ext_push(16'hB002);
        ext_valid = 1'b1; ext_data = 16'hB003;
        io_read(BASE, rdata);
        ext_valid = 1'b0;
        check_eq("pushpop_data", rdata, 16'hB001);
        io_read(BASE + 8'd1, rdata);
        check_eq("pushpop_status", rdata, 16'h0000);
        io_read(BASE, rdata);
        check_eq("pushpop_next1", rdata, 16'hB002);
        io_read(BASE, rdata);
        check_eq("pushpop_next2", rdata, 16'hB003);

        // flush concurrent with push: flush wins
        ext_push(16'hC001);
        ext_valid = 1'b1; ext_data = 16'hC002;
        io_write(BASE + 8'd3, 16'h0001);
        ext_valid = 1'b0;
        io_read(BASE + 8'd1, rdata);
        check_eq("flush_status", rdata, 16'h0001);

        // read and write together: write done, read data 0
        io_addr = BASE + 8'd2; io_in = 16'h7777; io_rd = 1'b1; io_wr = 1'b1;
        tick();
        io_rd = 1'b0; io_wr = 1'b0;
        check_eq("rdwr_io_out",  io_out,  0);
        check_eq("rdwr_tx_data", tx_data, 16'h7777);

        // unmapped and write-only reads return 0
        io_read(BASE + 8'd4, rdata);
        check_eq("unmapped_rd", rdata, 0);
        io_read(BASE + 8'd2, rdata);
        check_eq("txdata_rd", rdata, 0);
        io_write(BASE - 8'd1, 16'h0003);
        io_read(BASE + 8'd1, rdata);
        check_eq("unmapped_wr_status", rdata, 16'h0005);

        // reset in the middle of traffic
        ext_push(16'hD001);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mid_rst_tx_valid", tx_valid, 0);
        check_eq("mid_rst_tx_data",  tx_data,  0);
        check_eq("mid_rst_ready",    ext_ready, 1);
        io_read(BASE + 8'd1, rdata);
        check_eq("mid_rst_status", rdata, 16'h0001);

`ifdef IO_PORT_IRQ_EN
        io_write(BASE + 8'd3, 16'h0004);
        ext_push(16'hE001);
        tick();
        check_eq("irq_set", irq, 1);
        io_read(BASE, rdata);
        check_eq("irq_pop_data", rdata, 16'hE001);
        tick();
        check_eq("irq_clear", irq, 0);
`endif

        // final report
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
